bus_transfer_ctrl: RTL and testbench

Destination ("write") end of the 32-bit datapath bus. Accepts register-transfer requests (source code, destination code) over a valid/ready handshake, drives the 5-bit bus-source select toward the bus multiplexer, captures the returned bus value and loads it into the addressed register. Owns the 16 GPRs plus HI/LO, whose outputs feed the bus multiplexer inputs of the same names.

---
 rtl/bus_transfer_ctrl_if.sv | 39 +++
 rtl/bus_transfer_ctrl.sv | 136 +++++++++++++
 tb/tb_bus_transfer_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_ctrl_if.sv
// Request/bus handshake bundle for bus_transfer_ctrl.
// master: requester and bus-mux side; slave: the transfer controller.
interface bus_transfer_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5
) ();

   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] src_sel;
   logic [SEL_W-1:0] dst_sel;
   logic [WIDTH-1:0] bus_in;
   logic [SEL_W-1:0] bus_select;
   logic             done;
   logic             err;

   modport master (
      output req_valid,
      output src_sel,
      output dst_sel,
      output bus_in,
      input  req_ready,
      input  bus_select,
      input  done,
      input  err
   );

   modport slave (
      input  req_valid,
      input  src_sel,
      input  dst_sel,
      input  bus_in,
      output req_ready,
      output bus_select,
      output done,
      output err
   );

endinterface

// File: rtl/bus_transfer_ctrl.sv
// Write end of the datapath bus. It takes src/dst transfer requests,
// drives the bus-mux select, then loads bus_in into R0-R15/HI/LO.
// Ports: clock, clear (sync, active-high), bus (slave handshake/bus),
// R0..R15, HI, LO (register contents fed back to the bus mux).
module bus_transfer_ctrl #(
   parameter int WIDTH   = 32,
   parameter int SEL_W   = 5,
   parameter int MAX_SRC = 23,
   parameter int MAX_DST = 17
) (
   input  logic               clock,
   input  logic               clear,
   bus_transfer_ctrl_if.slave bus,
   output logic [WIDTH-1:0]   R0,
   output logic [WIDTH-1:0]   R1,
   output logic [WIDTH-1:0]   R2,
   output logic [WIDTH-1:0]   R3,
   output logic [WIDTH-1:0]   R4,
   output logic [WIDTH-1:0]   R5,
   output logic [WIDTH-1:0]   R6,
   output logic [WIDTH-1:0]   R7,
   output logic [WIDTH-1:0]   R8,
   output logic [WIDTH-1:0]   R9,
   output logic [WIDTH-1:0]   R10,
   output logic [WIDTH-1:0]   R11,
   output logic [WIDTH-1:0]   R12,
   output logic [WIDTH-1:0]   R13,
   output logic [WIDTH-1:0]   R14,
   output logic [WIDTH-1:0]   R15,
   output logic [WIDTH-1:0]   HI,
   output logic [WIDTH-1:0]   LO
);

   localparam int NREG = MAX_DST + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] src_q, src_d;
   logic [SEL_W-1:0] dst_q, dst_d;
   logic             rej_q, rej_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   logic src_bad;
   logic dst_bad;

   assign src_bad = bus.src_sel > SEL_W'(MAX_SRC);
   assign dst_bad = bus.dst_sel > SEL_W'(MAX_DST);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rej_d   = rej_q;
      regs_d  = regs_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               src_d = bus.src_sel;
               dst_d = bus.dst_sel;
               // rejected codes skip the bus phases entirely
               if (src_bad || dst_bad) begin
                  rej_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  rej_d   = 1'b0;
                  state_d = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // dst_q is always legal here; illegal codes never reach LOAD
            regs_d[dst_q] = bus.bus_in;
            state_d       = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rej_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rej_q   <= rej_d;
         regs_q  <= regs_d;
      end
   end

   // select is live only while the mux output is being consumed
   assign bus.bus_select = (state_q == S_DRIVE || state_q == S_LOAD)
                           ? src_q : '0;
   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.done       = (state_q == S_RESP) && !rej_q;
   assign bus.err        = (state_q == S_RESP) && rej_q;

   assign R0  = regs_q[0];
   assign R1  = regs_q[1];
   assign R2  = regs_q[2];
   assign R3  = regs_q[3];
   assign R4  = regs_q[4];
   assign R5  = regs_q[5];
   assign R6  = regs_q[6];
   assign R7  = regs_q[7];
   assign R8  = regs_q[8];
   assign R9  = regs_q[9];
   assign R10 = regs_q[10];
   assign R11 = regs_q[11];
   assign R12 = regs_q[12];
   assign R13 = regs_q[13];
   assign R14 = regs_q[14];
   assign R15 = regs_q[15];
   assign HI  = regs_q[16];
   assign LO  = regs_q[17];

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed self-checking bench for bus_transfer_ctrl.
// Each scenario task drives requests and checks outputs cycle by cycle.
module tb_bus_transfer_ctrl;

   logic        clock;
   logic        clear;
   logic [31:0] rq  [18];
   logic [31:0] exp_r [18];
   int          total;
   int          bad;

   bus_transfer_ctrl_if #(.WIDTH(32), .SEL_W(5)) bus ();

   bus_transfer_ctrl dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave),
      .R0    (rq[0]),
      .R1    (rq[1]),
      .R2    (rq[2]),
      .R3    (rq[3]),
      .R4    (rq[4]),
      .R5    (rq[5]),
      .R6    (rq[6]),
      .R7    (rq[7]),
      .R8    (rq[8]),
      .R9    (rq[9]),
      .R10   (rq[10]),
      .R11   (rq[11]),
      .R12   (rq[12]),
      .R13   (rq[13]),
      .R14   (rq[14]),
      .R15   (rq[15]),
      .HI    (rq[16]),
      .LO    (rq[17])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // advance one cycle; inputs are driven and outputs sampled 1ns later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 18; i++) begin
         total++;
         if (rq[i] !== exp_r[i]) begin
            bad++;
            $display("FAIL %s reg%0d got=%h want=%h", tag, i, rq[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_reset();
      clear         = 1'b1;
      bus.req_valid = 1'b1;
      bus.src_sel   = 5'd21;
      bus.dst_sel   = 5'd0;
      bus.bus_in    = 32'hCAFEF00D;
      tick();
      tick();
      clear         = 1'b0;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 18; i++) exp_r[i] = '0;
      check_regs("reset");
      total++;
      if (bus.bus_select !== 5'd0) begin
         bad++;
         $display("FAIL reset_sel got=%0d want=0", bus.bus_select);
      end
      total++;
      if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL reset_pulse got=%b%b want=00", bus.done, bus.err);
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", bus.req_ready);
      end
   endtask

   task automatic test_basic();
      bus.bus_in    = 32'hDEADBEEF;
      bus.src_sel   = 5'd21;
      bus.dst_sel   = 5'd3;
      bus.req_valid = 1'b1;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_ready got=%b want=1", bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.bus_select !== 5'd21 || bus.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_drive got=sel%0d rdy%b want=sel21 rdy0",
                  bus.bus_select, bus.req_ready);
      end
      tick();
      total++;
      if (bus.bus_select !== 5'd21 || rq[3] !== 32'h0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL basic_load got=sel%0d r3=%h done%b want=sel21 r3=0 done0",
                  bus.bus_select, rq[3], bus.done);
      end
      tick();
      exp_r[3] = 32'hDEADBEEF;
      check_regs("basic_n3");
      total++;
      if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.bus_select !== 5'd0) begin
         bad++;
         $display("FAIL basic_resp got=done%b err%b sel%0d want=done1 err0 sel0",
                  bus.done, bus.err, bus.bus_select);
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_idle got=done%b rdy%b want=done0 rdy1",
                  bus.done, bus.req_ready);
      end
   endtask

   task automatic test_hilo();
      bus.bus_in    = 32'h80000001;
      bus.src_sel   = 5'd18;
      bus.dst_sel   = 5'd16;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.bus_select !== 5'd18) begin
         bad++;
         $display("FAIL hi_sel got=%0d want=18", bus.bus_select);
      end
      tick();
      tick();
      exp_r[16] = 32'h80000001;
      check_regs("hi_load");
      total++;
      if (bus.done !== 1'b1) begin
         bad++;
         $display("FAIL hi_done got=%b want=1", bus.done);
      end
      tick();
      bus.bus_in    = 32'hFFFFFFFF;
      bus.src_sel   = 5'd19;
      bus.dst_sel   = 5'd17;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      exp_r[17] = 32'hFFFFFFFF;
      check_regs("lo_load");
      total++;
      if (bus.done !== 1'b1) begin
         bad++;
         $display("FAIL lo_done got=%b want=1", bus.done);
      end
      tick();
   endtask

   task automatic test_illegal();
      bus.bus_in    = 32'hAAAA5555;
      bus.src_sel   = 5'd24;
      bus.dst_sel   = 5'd2;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.bus_select !== 5'd0) begin
         bad++;
         $display("FAIL ill_src got=err%b done%b sel%0d want=err1 done0 sel0",
                  bus.err, bus.done, bus.bus_select);
      end
      tick();
      total++;
      if (bus.err !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ill_idle got=err%b rdy%b want=err0 rdy1",
                  bus.err, bus.req_ready);
      end
      bus.src_sel   = 5'd5;
      bus.dst_sel   = 5'd18;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.err !== 1'b1 || bus.bus_select !== 5'd0) begin
         bad++;
         $display("FAIL ill_dst got=err%b sel%0d want=err1 sel0",
                  bus.err, bus.bus_select);
      end
      tick();
      tick();
      tick();
      check_regs("ill_nowrite");
   endtask

   task automatic test_back_to_back();
      int ndone;
      ndone         = 0;
      bus.bus_in    = 32'h11111111;
      bus.src_sel   = 5'd21;
      bus.dst_sel   = 5'd4;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.req_ready !== (i % 4 == 0)) begin
            bad++;
            $display("FAIL b2b_ready c%0d got=%b want=%b",
                     i, bus.req_ready, (i % 4 == 0));
         end
         total++;
         if (bus.done !== (i % 4 == 3)) begin
            bad++;
            $display("FAIL b2b_done c%0d got=%b want=%b",
                     i, bus.done, (i % 4 == 3));
         end
         if (bus.done === 1'b1) ndone++;
         if (i == 1) bus.dst_sel = 5'd9;
         if (i == 3) begin
            exp_r[4] = 32'h11111111;
            check_regs("b2b_first");
         end
         if (i == 4) bus.bus_in = 32'h22222222;
         if (i == 7) begin
            exp_r[9] = 32'h22222222;
            check_regs("b2b_second");
         end
         if (i == 7) bus.req_valid = 1'b0;
         tick();
      end
      total++;
      if (ndone != 2) begin
         bad++;
         $display("FAIL b2b_count got=%0d want=2", ndone);
      end
   endtask

   task automatic test_self_copy();
      bus.bus_in    = exp_r[4];
      bus.src_sel   = 5'd4;
      bus.dst_sel   = 5'd4;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      total++;
      if (bus.bus_select !== 5'd4) begin
         bad++;
         $display("FAIL self_sel got=%0d want=4", bus.bus_select);
      end
      tick();
      tick();
      check_regs("self_copy");
      total++;
      if (bus.done !== 1'b1) begin
         bad++;
         $display("FAIL self_done got=%b want=1", bus.done);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.bus_in    = 32'h12345678;
      bus.src_sel   = 5'd21;
      bus.dst_sel   = 5'd7;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      total++;
      if (bus.bus_select !== 5'd21) begin
         bad++;
         $display("FAIL mid_load got=%0d want=21", bus.bus_select);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 18; i++) exp_r[i] = '0;
      check_regs("mid_clear");
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_after c%0d got=done%b rdy%b want=done0 rdy1",
                     i, bus.done, bus.req_ready);
         end
         tick();
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      clear         = 1'b0;
      bus.req_valid = 1'b0;
      bus.src_sel   = '0;
      bus.dst_sel   = '0;
      bus.bus_in    = '0;
      #1;
      test_reset();
      test_basic();
      test_hilo();
      test_illegal();
      test_back_to_back();
      test_self_copy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
